// File: rtl/strip_frame_loader.sv
// Loads one frame from a single pixel stream into STRIP_COUNT strip pixel RAMs, checking frame length.
// Optional idle-stream abort is enabled with `define STRIP_FRAME_LOADER_TIMEOUT_EN.
module strip_frame_loader #(
    parameter int STRIP_COUNT    = 8,
    parameter int LED_COUNT      = 300,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   frame_start_i,
    input  logic                   pixel_valid_i,
    output logic                   pixel_ready_o,
    input  logic                   pixel_last_i,
    input  logic [7:0]             pixel_r_i,
    input  logic [7:0]             pixel_g_i,
    input  logic [7:0]             pixel_b_i,
    output logic [7:0]             pixel_r_o,
    output logic [7:0]             pixel_g_o,
    output logic [7:0]             pixel_b_o,
    output logic [8:0]             led_address_o,
    output logic                   led_address_valid_o,
    output logic [STRIP_COUNT-1:0] strip_select_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   frame_error_o
);
    localparam int              SW         = (STRIP_COUNT > 1) ? $clog2(STRIP_COUNT) : 1;
    localparam logic [8:0]      LAST_ADDR  = 9'(LED_COUNT - 1);
    localparam logic [SW-1:0]   LAST_STRIP = SW'(STRIP_COUNT - 1);

    if (STRIP_COUNT < 1 || STRIP_COUNT > 16 || LED_COUNT < 1 || LED_COUNT > 512 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("strip_frame_loader: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [8:0]             addr_q;
    logic [SW-1:0]          strip_q;
    logic [7:0]             r_q, g_q, b_q;
    logic [8:0]             led_addr_q;
    logic [STRIP_COUNT-1:0] sel_q;
    logic                   strobe_q, done_q, error_q;
    logic                   active, acc, last_slot;

    assign active    = (state_q == LOAD) || (state_q == DRAIN);
    assign acc       = pixel_valid_i && active;
    assign last_slot = (strip_q == LAST_STRIP) && (addr_q == LAST_ADDR);

`ifdef STRIP_FRAME_LOADER_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        timeout;
    // Restart takes priority over a timeout landing in the same cycle.
    assign timeout = active && !acc && !frame_start_i && (idle_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            strip_q    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            led_addr_q <= '0;
            sel_q      <= STRIP_COUNT'(1);
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef STRIP_FRAME_LOADER_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                        strip_q <= '0;
                    end
                end
                LOAD: begin
                    if (frame_start_i) begin
                        error_q <= 1'b1;
                        addr_q  <= '0;
                        strip_q <= '0;
                    end else if (acc) begin
                        strobe_q   <= 1'b1;
                        led_addr_q <= addr_q;
                        sel_q      <= STRIP_COUNT'(1) << strip_q;
                        r_q        <= pixel_r_i;
                        g_q        <= pixel_g_i;
                        b_q        <= pixel_b_i;
                        if (last_slot || pixel_last_i) begin
                            addr_q  <= '0;
                            strip_q <= '0;
                        end else if (addr_q == LAST_ADDR) begin
                            addr_q  <= '0;
                            strip_q <= strip_q + SW'(1);
                        end else begin
                            addr_q  <= addr_q + 9'd1;
                        end
                        if (last_slot) begin
                            state_q <= pixel_last_i ? DONE : DRAIN;
                            done_q  <= pixel_last_i;
                        end else if (pixel_last_i) begin
                            state_q <= IDLE;
                            error_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (frame_start_i) begin
                        state_q <= LOAD;
                        error_q <= 1'b1;
                        addr_q  <= '0;
                        strip_q <= '0;
                    end else if (acc && pixel_last_i) begin
                        state_q <= IDLE;
                        error_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef STRIP_FRAME_LOADER_TIMEOUT_EN
            if (!active || acc || frame_start_i || timeout) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 16'd1;
            end
            if (timeout) begin
                state_q <= IDLE;
                error_q <= 1'b1;
                addr_q  <= '0;
                strip_q <= '0;
            end
`endif
        end
    end

    assign pixel_ready_o       = active;
    assign busy_o              = (state_q != IDLE);
    assign pixel_r_o           = r_q;
    assign pixel_g_o           = g_q;
    assign pixel_b_o           = b_q;
    assign led_address_o       = led_addr_q;
    assign led_address_valid_o = strobe_q;
    assign strip_select_o      = sel_q;
    assign frame_done_o        = done_q;
    assign frame_error_o       = error_q;
endmodule

// File: tb/tb_strip_frame_loader.sv
// Directed bench for strip_frame_loader with STRIP_COUNT=2, LED_COUNT=4, TIMEOUT_CYCLES=16.
module tb_strip_frame_loader;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_start_i = 1'b0, pixel_valid_i = 1'b0, pixel_last_i = 1'b0;
    logic [7:0] pixel_r_i = '0, pixel_g_i = '0, pixel_b_i = '0;
    logic       pixel_ready_o, led_address_valid_o, busy_o, frame_done_o, frame_error_o;
    logic [7:0] pixel_r_o, pixel_g_o, pixel_b_o;
    logic [8:0] led_address_o;
    logic [1:0] strip_select_o;

    strip_frame_loader #(.STRIP_COUNT(2), .LED_COUNT(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i),
        .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o), .pixel_last_i(pixel_last_i),
        .pixel_r_i(pixel_r_i), .pixel_g_i(pixel_g_i), .pixel_b_i(pixel_b_i),
        .pixel_r_o(pixel_r_o), .pixel_g_o(pixel_g_o), .pixel_b_o(pixel_b_o),
        .led_address_o(led_address_o), .led_address_valid_o(led_address_valid_o),
        .strip_select_o(strip_select_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .frame_error_o(frame_error_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0;
    int s_addr[$], s_sel[$], s_rgb[$], s_cyc[$], acc_cyc[$];
    int n_done = 0, n_err = 0, n_both = 0, err_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (led_address_valid_o) begin
                s_addr.push_back(int'(led_address_o));
                s_sel.push_back(int'(strip_select_o));
                s_rgb.push_back(int'({pixel_r_o, pixel_g_o, pixel_b_o}));
                s_cyc.push_back(cyc);
            end
            if (frame_done_o) n_done++;
            if (frame_error_o) begin
                n_err++;
                err_cyc = cyc;
            end
            if (frame_done_o && frame_error_o) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic s, input int colour);
        @(negedge clk);
        pixel_valid_i = v;
        pixel_last_i  = l;
        frame_start_i = s;
        {pixel_r_i, pixel_g_i, pixel_b_i} = 24'(32'h010101 * colour);
        if (v && pixel_ready_o) acc_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear_log();
        s_addr.delete(); s_sel.delete(); s_rgb.delete(); s_cyc.delete(); acc_cyc.delete();
        n_done = 0; n_err = 0; err_cyc = 0;
    endtask

    // Strobe j of a run is expected at addr j%4 on strip j/4 carrying colour base+j.
    task automatic check_strobes(input string tag, input int qoff, input int n, input int base);
        for (int j = 0; j < n; j++) begin
            if (qoff + j < s_addr.size()) begin
                chk({tag, "_addr"}, s_addr[qoff+j], j % 4);
                chk({tag, "_sel"}, s_sel[qoff+j], 1 << (j / 4));
                chk({tag, "_rgb"}, s_rgb[qoff+j], 32'h010101 * (base + j));
            end
        end
    endtask

    task automatic check_latency(input string tag);
        for (int k = 0; k < s_cyc.size(); k++)
            if (k < acc_cyc.size()) chk({tag, "_lat"}, s_cyc[k] - acc_cyc[k], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_rs;
        repeat (3) @(negedge clk);
        chk("rst_sel", strip_select_o, 2'b01);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", pixel_ready_o, 0);
        chk("rst_strobe", led_address_valid_o, 0);
        chk("rst_addr", led_address_o, 0);
        chk("rst_flags", {frame_done_o, frame_error_o}, 0);
        rst_i = 1'b0;

        // Valid while idle is ignored
        clear_log();
        step(1'b1, 1'b0, 1'b0, 9); step(1'b1, 1'b1, 1'b0, 9); idle(2);
        chk("idle_strobes", s_addr.size(), 0);
        chk("idle_ready", pixel_ready_o, 0);

        // Back-to-back full frame
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 8; i++) step(1'b1, i == 8, 1'b0, i);
        idle(3);
        chk("b2b_count", s_addr.size(), 8);
        check_strobes("b2b", 0, 8, 1);
        check_latency("b2b");
        chk("b2b_done", n_done, 1);
        chk("b2b_err", n_err, 0);
        chk("b2b_busy", busy_o, 0);

        // Valid toggled every other cycle
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i == 8, 1'b0, i);
            step(1'b0, 1'b0, 1'b0, 0);
        end
        idle(2);
        chk("tog_count", s_addr.size(), 8);
        check_strobes("tog", 0, 8, 1);
        check_latency("tog");
        chk("tog_done", n_done, 1);
        chk("tog_busy", busy_o, 0);

        // Short frame: last on pixel 5
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 5; i++) step(1'b1, i == 5, 1'b0, i);
        idle(2);
        chk("short_count", s_addr.size(), 5);
        check_strobes("short", 0, 5, 1);
        chk("short_err", n_err, 1);
        chk("short_done", n_done, 0);
        chk("short_busy", busy_o, 0);

        // Long frame: 10 pixels, last on pixel 10
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 10; i++) step(1'b1, i == 10, 1'b0, i);
        idle(2);
        chk("long_count", s_addr.size(), 8);
        check_strobes("long", 0, 8, 1);
        chk("long_accepts", acc_cyc.size(), 10);
        chk("long_err", n_err, 1);
        if (acc_cyc.size() == 10) chk("long_err_cyc", err_cyc, acc_cyc[9] + 1);
        chk("long_done", n_done, 0);
        chk("long_busy", busy_o, 0);

        // Restart coincident with the third accepted pixel
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 1'b1, 3);
        t_rs = cyc;
        for (int i = 0; i < 8; i++) step(1'b1, i == 7, 1'b0, 4 + i);
        idle(2);
        chk("rs_count", s_addr.size(), 10);
        check_strobes("rs_pre", 0, 2, 1);
        check_strobes("rs_post", 2, 8, 4);
        chk("rs_err", n_err, 1);
        chk("rs_err_cyc", err_cyc, t_rs + 1);
        chk("rs_done", n_done, 0 + 1);
        chk("rs_busy", busy_o, 0);

        // Asynchronous reset mid-LOAD
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 2);
        @(posedge clk);
        #2;
        chk("ar_pre_strobe", led_address_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("ar_strobe", led_address_valid_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_ready", pixel_ready_o, 0);
        chk("ar_sel", strip_select_o, 2'b01);
        chk("ar_addr", led_address_o, 0);
        chk("ar_rgb", {pixel_r_o, pixel_g_o, pixel_b_o}, 0);
        @(negedge clk);
        pixel_valid_i = 1'b0;
        rst_i = 1'b0;
        idle(1);

`ifdef STRIP_FRAME_LOADER_TIMEOUT_EN
        clear_log();
        step(1'b0, 1'b0, 1'b1, 0);
        idle(15);
        chk("to_early", n_err, 0);
        idle(5);
        chk("to_err", n_err, 1);
        chk("to_busy", busy_o, 0);
`endif

        chk("done_err_overlap", n_both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/strip_frame_loader.md
Name: strip_frame_loader

Overview:
Sequences one frame of pixel data from a single upstream pixel stream into the pixel RAMs of STRIP_COUNT WS2812 strip drivers. It owns the shared pixel write port and generates the address, write strobe and one-hot strip select. It also checks frame length and reports completion or error. It sits between the host/bus pixel source and the array of strip drivers, all in the pixel clock domain.

Parameters:
STRIP_COUNT, 8, number of strips served (1..16)
LED_COUNT, 300, LEDs per strip (1..512); the address range is 0..LED_COUNT-1
TIMEOUT_CYCLES, 65535, idle-stream abort threshold in clocks; used only with the optional feature

Ports:
clk_i  in  1  pixel clock; all logic is clocked on the rising edge
rst_i  in  1  reset, asynchronous, active-high
frame_start_i  in  1  single-cycle pulse that begins a frame load
pixel_valid_i  in  1  upstream pixel valid
pixel_ready_o  out  1  loader accepts the pixel this cycle
pixel_last_i  in  1  marks the final pixel of a frame; qualified by valid&&ready
pixel_r_i / pixel_g_i / pixel_b_i  in  8 each  upstream colour
pixel_r_o / pixel_g_o / pixel_b_o  out  8 each  registered colour to the strip RAM write port
led_address_o  out  9  registered LED address within the selected strip
led_address_valid_o  out  1  write strobe, one cycle per written pixel
strip_select_o  out  STRIP_COUNT  one-hot strip enable; the strobe is ANDed per strip externally
busy_o  out  1  high whenever state != IDLE
frame_done_o  out  1  single-cycle pulse: full frame written with correct length
frame_error_o  out  1  single-cycle pulse: length error, restart, or timeout

Behaviour:
- Reset (async assert): state=IDLE; all counters 0; every output 0 except strip_select_o=1 (strip 0 selected).
- States: IDLE, LOAD, DRAIN, DONE.
- Accept condition: acc = pixel_valid_i && pixel_ready_o.
- pixel_ready_o = 1 in LOAD and DRAIN; 0 in IDLE and DONE.
- IDLE:
  - frame_start_i -> LOAD, with addr=0, strip=0.
  - pixel_valid_i is ignored (ready=0).
- LOAD, on each acc:
  - Next cycle: led_address_valid_o=1; led_address_o=addr; strip_select_o=onehot(strip); colour outputs equal the accepted colour. Latency is exactly 1 clock.
  - Otherwise led_address_valid_o=0, and address, select and colour hold their last values.
  - Counter update: if addr==LED_COUNT-1, then addr<=0 and strip<=strip+1; else addr<=addr+1.
  - Final slot (strip==STRIP_COUNT-1 && addr==LED_COUNT-1):
    - pixel_last_i=1 -> DONE.
    - pixel_last_i=0 -> DRAIN (pixel is written; frame too long).
  - pixel_last_i=1 before the final slot: pixel is written; frame_error_o pulses next cycle; state -> IDLE (frame too short). Unwritten LEDs keep their old RAM contents.
- DRAIN:
  - Accepts and discards pixels; led_address_valid_o stays 0.
  - On acc with pixel_last_i=1: frame_error_o pulses next cycle; state -> IDLE.
- DONE: frame_done_o=1 for one cycle, then IDLE.
- frame_start_i while in LOAD or DRAIN:
  - frame_error_o pulses next cycle; addr and strip reset to 0; state=LOAD.
  - Restart has priority: a pixel accepted in the same cycle is discarded (no strobe).
- frame_start_i in DONE: ignored. Upstream must wait until busy_o=0.
- frame_done_o and frame_error_o never assert in the same cycle.
- Widths: addr is 9 bits; strip index is clog2(STRIP_COUNT) bits (minimum 1). Counters never exceed their limits.

Optional Feature:
STRIP_FRAME_LOADER_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter clears on every acc and on entry to LOAD, and increments each LOAD/DRAIN cycle without acc.
  - When it reaches TIMEOUT_CYCLES: frame_error_o pulses for one cycle; state -> IDLE; counters clear.
- Undefined: no counter; LOAD and DRAIN wait indefinitely.

Test Plan:
- STRIP_COUNT=2, LED_COUNT=4: start, then 8 back-to-back pixels 0x010101..0x080808 with last on the 8th:
  - strobes at addr 0,1,2,3 with select 01, then addr 0,1,2,3 with select 10;
  - each strobe occurs 1 clk after acceptance;
  - frame_done_o pulses once; busy_o falls.
- Same config, valid toggled every other cycle: strobes only follow accepted cycles, address sequence is identical, one done pulse.
- Short frame: pixel_last_i on the 5th pixel:
  - 5 strobes, ending at strip 1 addr 0;
  - frame_error_o pulses; state=IDLE; no done pulse.
- Long frame: 10 pixels, last on the 10th:
  - 8 strobes; pixels 9-10 accepted with no strobe;
  - single error pulse after the 10th.
- Restart: frame_start_i coincident with the 3rd accepted pixel:
  - error pulse; that pixel produces no strobe;
  - next accepted pixel is written at strip 0 addr 0.
- Async reset asserted mid-LOAD without a clock edge: all outputs go to reset values immediately. With STRIP_FRAME_LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: start, then 16 idle cycles -> error pulse, busy_o=0.
